// File: rtl/accum_pkg.sv
// Shared types for the MAC / accumulator-reader pair.
package accum_pkg;

  localparam int unsigned Z_WIDTH_DEF = 38;

  typedef logic [Z_WIDTH_DEF-1:0] z_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage : accum_pkg

// File: rtl/accum_fifo2.sv
// Two-entry valid/ready FIFO; head entry is a register driving the stream output.
module accum_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head_q, tail_q;
  logic         head_v_q, tail_v_q;
  logic         do_pop_c, do_push_c;

  assign do_pop_c  = pop && head_v_q;
  assign do_push_c = push && (!tail_v_q || do_pop_c);

  // Tail shifts into head on pop; new data lands in the first free slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
    end else if (do_pop_c) begin
      if (tail_v_q) begin
        head_q <= tail_q;
        if (do_push_c) begin
          tail_q <= push_data;
        end else begin
          tail_v_q <= 1'b0;
        end
      end else if (do_push_c) begin
        head_q <= push_data;
      end else begin
        head_v_q <= 1'b0;
      end
    end else if (do_push_c) begin
      if (!head_v_q) begin
        head_q   <= push_data;
        head_v_q <= 1'b1;
      end else begin
        tail_q   <= push_data;
        tail_v_q <= 1'b1;
      end
    end
  end

  assign head       = head_q;
  assign head_valid = head_v_q;
  assign full       = tail_v_q;
  assign empty      = !head_v_q;

endmodule : accum_fifo2

// File: rtl/accum_delta_reader.sv
// Recovers per-cycle products from a running accumulator stream (z_n - z_(n-1))
// and emits them through a 2-entry valid/ready buffer, framed by FRAME_LEN.
module accum_delta_reader
  import accum_pkg::*;
#(
  parameter int unsigned Z_WIDTH   = Z_WIDTH_DEF,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Z_WIDTH-1:0] z_in,
  input  logic               z_valid,
  output logic [Z_WIDTH-1:0] d_out,
  output logic               d_valid,
  input  logic               d_ready,
  output logic               frame_done,
  output logic               err_overflow,
  output logic [15:0]        sample_cnt
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);

  rd_state_t          state_q, state_d;
  logic [Z_WIDTH-1:0] z_prev_q, z_prev_d;
  logic [Z_WIDTH-1:0] delta_c;
  logic [CNT_W-1:0]   cnt_d;
  logic               err_d, frame_done_d;
  logic               pop_c, push_c, accept_c;
  logic               fifo_full, fifo_empty;

  assign pop_c   = d_valid && d_ready;
  assign delta_c = z_in - z_prev_q;

  // Next-state and register-update decode.
  always_comb begin
    state_d      = state_q;
    z_prev_d     = z_prev_q;
    cnt_d        = sample_cnt;
    err_d        = err_overflow;
    frame_done_d = 1'b0;
    push_c       = 1'b0;
    accept_c     = z_valid && (state_q != DRAIN) && (!fifo_full || pop_c);

    // Any sample that cannot be taken is lost for good.
    if (z_valid && !accept_c) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          push_c   = 1'b1;
          z_prev_d = z_in;
          cnt_d    = CNT_ONE;
          state_d  = (CNT_LAST == CNT_ONE) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept_c) begin
          push_c   = 1'b1;
          z_prev_d = z_in;
          cnt_d    = sample_cnt + CNT_ONE;
          if (cnt_d == CNT_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Frame closes on the pop that leaves the buffer empty.
        if (fifo_empty || (pop_c && !fifo_full)) begin
          frame_done_d = 1'b1;
          z_prev_d     = '0;
          cnt_d        = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      z_prev_q     <= '0;
      sample_cnt   <= '0;
      err_overflow <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      z_prev_q     <= z_prev_d;
      sample_cnt   <= cnt_d;
      err_overflow <= err_d;
      frame_done   <= frame_done_d;
    end
  end

  accum_fifo2 #(
    .W(Z_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (delta_c),
    .pop       (pop_c),
    .head      (d_out),
    .head_valid(d_valid),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule : accum_delta_reader
